decoder_arbiter: RTL and testbench

DECODER_ARBITER -- requirements
Module: decoder_arbiter

---
 rtl/dec_arb_pkg.sv | 15 +
 rtl/hit_fifo.sv | 64 ++++++
 rtl/decoder_arbiter.sv | 173 +++++++++++++++++
 tb/tb_decoder_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_arb_pkg.sv
// Shared defaults and tag type for the two-channel decoder arbiter.
package dec_arb_pkg;

  localparam int DEF_DATA_W     = 40;
  localparam int DEF_POS_W      = 6;
  localparam int DEF_DEC_LAT    = 7;
  localparam int DEF_FIFO_DEPTH = 4;

  // Travels beside the shared decoder so its result can be routed to the right channel.
  typedef struct packed {
    logic vld;
    logic ch;
  } tag_t;

endpackage

// File: rtl/hit_fifo.sv
// Per-channel synchronous hit buffer with registered occupancy counter.
module hit_fifo
  import dec_arb_pkg::*;
#(
  parameter int W     = DEF_DATA_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_ok, rd_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // A full buffer still takes a word when the head leaves in the same cycle.
  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/decoder_arbiter.sv
// Two hit channels sharing one pipelined thermometer decoder via round-robin arbitration.
// Optional saturating hit/drop statistics are built only when DEC_ARB_STATS_EN is defined.
module decoder_arbiter
  import dec_arb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int POS_W      = DEF_POS_W,
  parameter int DEC_LAT    = DEF_DEC_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ch0_valid,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic              ch1_valid,
  input  logic [DATA_W-1:0] ch1_data,
  output logic [DATA_W-1:0] dec_data,
  input  logic [POS_W-1:0]  dec_result,
  output logic              res0_valid,
  output logic [POS_W-1:0]  res0_pos,
  output logic              res1_valid,
  output logic [POS_W-1:0]  res1_pos,
  output logic              ovf0,
  output logic              ovf1,
  input  logic              clr_ovf,
  output logic [15:0]       hits0,
  output logic [15:0]       hits1,
  output logic [15:0]       drops0,
  output logic [15:0]       drops1
);

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  logic [1:0]        in_vld, wr_en, pop, full, empty, drop;
  logic [DATA_W-1:0] in_data [2];
  logic [DATA_W-1:0] rd_data [2];

  logic              grant_vld, grant_ch;
  logic              last_ch_q, last_ch_d;
  logic [DATA_W-1:0] dec_data_q, dec_data_d;

  tag_t [DEC_LAT-1:0] tag_q, tag_d;
  tag_t               out_tag;

  logic [1:0]            res_vld_q, res_vld_d;
  logic [1:0][POS_W-1:0] res_pos_q, res_pos_d;
  logic [1:0]            ovf_q, ovf_d;

  // Assertion is immediate; release is retimed through two flops.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_int_n  = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign in_vld     = {ch1_valid, ch0_valid};
  assign in_data[0] = ch0_data;
  assign in_data[1] = ch1_data;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    hit_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_int_n),
      .wr_en   (wr_en[g]),
      .wr_data (in_data[g]),
      .rd_en   (pop[g]),
      .rd_data (rd_data[g]),
      .full    (full[g]),
      .empty   (empty[g])
    );
  end

  // last_ch_q holds the previous grant; on contention the other channel wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = 1'b0;
    pop       = '0;
    if (!empty[0] && !empty[1]) begin
      grant_vld = 1'b1;
      grant_ch  = ~last_ch_q;
    end else if (!empty[0]) begin
      grant_vld = 1'b1;
      grant_ch  = 1'b0;
    end else if (!empty[1]) begin
      grant_vld = 1'b1;
      grant_ch  = 1'b1;
    end
    pop[grant_ch] = grant_vld;
    last_ch_d     = grant_vld ? grant_ch : last_ch_q;
    dec_data_d    = grant_vld ? rd_data[grant_ch] : '0;
    wr_en         = in_vld & (~full | pop);
    drop          = in_vld & full & ~pop;
  end

  always_comb begin
    tag_d     = {tag_q[DEC_LAT-2:0], tag_t'{vld: grant_vld, ch: grant_ch}};
    out_tag   = tag_q[DEC_LAT-1];
    res_vld_d = {out_tag.vld & out_tag.ch, out_tag.vld & ~out_tag.ch};
    for (int i = 0; i < 2; i++) begin
      res_pos_d[i] = res_vld_d[i] ? dec_result : res_pos_q[i];
    end
    // A drop in the same cycle as clr_ovf keeps the flag set.
    ovf_d = drop | (ovf_q & {2{~clr_ovf}});
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      last_ch_q  <= 1'b1;
      dec_data_q <= '0;
      tag_q      <= '0;
      res_vld_q  <= '0;
      res_pos_q  <= '0;
      ovf_q      <= '0;
    end else begin
      last_ch_q  <= last_ch_d;
      dec_data_q <= dec_data_d;
      tag_q      <= tag_d;
      res_vld_q  <= res_vld_d;
      res_pos_q  <= res_pos_d;
      ovf_q      <= ovf_d;
    end
  end

  assign dec_data   = dec_data_q;
  assign res0_valid = res_vld_q[0];
  assign res1_valid = res_vld_q[1];
  assign res0_pos   = res_pos_q[0];
  assign res1_pos   = res_pos_q[1];
  assign ovf0       = ovf_q[0];
  assign ovf1       = ovf_q[1];

`ifdef DEC_ARB_STATS_EN
  logic [1:0][15:0] hits_q, hits_d, drops_q, drops_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hits_d[i]  = sat_inc(hits_q[i], wr_en[i]);
      drops_d[i] = sat_inc(drops_q[i], drop[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      hits_q  <= '0;
      drops_q <= '0;
    end else begin
      hits_q  <= hits_d;
      drops_q <= drops_d;
    end
  end

  assign hits0  = hits_q[0];
  assign hits1  = hits_q[1];
  assign drops0 = drops_q[0];
  assign drops1 = drops_q[1];
`else
  assign hits0  = '0;
  assign hits1  = '0;
  assign drops0 = '0;
  assign drops1 = '0;
`endif

endmodule

// File: tb/tb_decoder_arbiter.sv
// Directed bench for decoder_arbiter with a ones-count decoder model in the loop.
module tb_decoder_arbiter;
  import dec_arb_pkg::*;

  localparam int DATA_W     = DEF_DATA_W;
  localparam int POS_W      = DEF_POS_W;
  localparam int DEC_LAT    = DEF_DEC_LAT;
  localparam int FIFO_DEPTH = DEF_FIFO_DEPTH;

`ifdef DEC_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              ch0_valid = 1'b0, ch1_valid = 1'b0, clr_ovf = 1'b0;
  logic [DATA_W-1:0] ch0_data = '0, ch1_data = '0, dec_data;
  logic [POS_W-1:0]  dec_result, res0_pos, res1_pos;
  logic              res0_valid, res1_valid, ovf0, ovf1;
  logic [15:0]       hits0, hits1, drops0, drops1;

  always #5 clk = ~clk;

  decoder_arbiter #(
    .DATA_W     (DATA_W),
    .POS_W      (POS_W),
    .DEC_LAT    (DEC_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch0_valid  (ch0_valid),
    .ch0_data   (ch0_data),
    .ch1_valid  (ch1_valid),
    .ch1_data   (ch1_data),
    .dec_data   (dec_data),
    .dec_result (dec_result),
    .res0_valid (res0_valid),
    .res0_pos   (res0_pos),
    .res1_valid (res1_valid),
    .res1_pos   (res1_pos),
    .ovf0       (ovf0),
    .ovf1       (ovf1),
    .clr_ovf    (clr_ovf),
    .hits0      (hits0),
    .hits1      (hits1),
    .drops0     (drops0),
    .drops1     (drops1)
  );

  function automatic logic [POS_W-1:0] ones(input logic [DATA_W-1:0] w);
    logic [POS_W-1:0] n = '0;
    for (int i = 0; i < DATA_W; i++) n += POS_W'(w[i]);
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] therm(input int n);
    logic [DATA_W-1:0] w = '0;
    for (int i = 0; i < n; i++) w[i] = 1'b1;
    return w;
  endfunction

  // Decoder model: dec_result lags dec_data by DEC_LAT edges, counting the edge that launches dec_data.
  logic [POS_W-1:0] dpipe [DEC_LAT-1];
  always @(posedge clk) begin
    dpipe[0] <= ones(dec_data);
    for (int i = 1; i < DEC_LAT - 1; i++) dpipe[i] <= dpipe[i-1];
  end
  assign dec_result = dpipe[DEC_LAT-2];

  int q0[$], q1[$], order[$];
  always @(negedge clk) begin
    if (res0_valid) begin q0.push_back(int'(res0_pos)); order.push_back(0); end
    if (res1_valid) begin q1.push_back(int'(res1_pos)); order.push_back(1); end
  end

  int n_vec = 0, n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_mon();
    q0.delete();
    q1.delete();
    order.delete();
  endtask

  task automatic idle_inputs();
    ch0_valid = 1'b0; ch1_valid = 1'b0; clr_ovf = 1'b0;
    ch0_data = '0; ch1_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clr_mon();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] ord_bits;
    #2;
    do_reset();

    // Reset state
    check_val("rst_dec_data", dec_data, '0);
    check_val("rst_res_valid", {res1_valid, res0_valid}, 2'b00);
    check_val("rst_res0_pos", res0_pos, '0);
    check_val("rst_res1_pos", res1_pos, '0);
    check_val("rst_ovf", {ovf1, ovf0}, 2'b00);
    check_val("rst_stats", {hits0, hits1, drops0, drops1}, '0);

    // Single ch0 hit: 8 ones -> pos 8, strobe after edge 9
    ch0_valid = 1'b1; ch0_data = 40'h00000000FF;
    tick();
    idle_inputs();
    tick();
    check_val("single_dec_data_e2", dec_data, 40'h00000000FF);
    tick();
    check_val("single_dec_data_e3", dec_data, '0);
    tick(5);
    check_val("single_early_e8", res0_valid, 1'b0);
    tick();
    check_val("single_valid_e9", res0_valid, 1'b1);
    check_val("single_pos_e9", res0_pos, 6'd8);
    check_val("single_res1_e9", res1_valid, 1'b0);
    tick();
    check_val("single_valid_e10", res0_valid, 1'b0);
    check_val("single_hold_e10", res0_pos, 6'd8);
    tick(5);
    check_val("single_cnt0", q0.size(), 1);
    check_val("single_cnt1", q1.size(), 0);

    // ch1 latency, then an all-zero word
    clr_mon();
    ch1_valid = 1'b1; ch1_data = therm(20);
    tick();
    idle_inputs();
    tick(7);
    check_val("ch1_early_e8", res1_valid, 1'b0);
    tick();
    check_val("ch1_valid_e9", res1_valid, 1'b1);
    check_val("ch1_pos_e9", res1_pos, 6'd20);
    check_val("ch1_res0_e9", res0_valid, 1'b0);
    ch1_valid = 1'b1; ch1_data = '0;
    tick();
    idle_inputs();
    tick(8);
    check_val("zero_valid", res1_valid, 1'b1);
    check_val("zero_pos", res1_pos, 6'd0);
    tick();
    check_val("zero_after", res1_valid, 1'b0);
    check_val("hold_res0", res0_pos, 6'd8);

    // Both channels for 7 cycles; ch1 is full but popped on the last write
    do_reset();
    for (int t = 0; t < 7; t++) begin
      ch0_valid = 1'b1; ch0_data = therm(t + 1);
      ch1_valid = 1'b1; ch1_data = therm(t + 10);
      tick();
    end
    idle_inputs();
    tick(30);
    check_val("rr_cnt0", q0.size(), 7);
    check_val("rr_cnt1", q1.size(), 7);
    for (int i = 0; i < 7 && i < q0.size(); i++) check_val($sformatf("rr_ch0_%0d", i), q0[i], i + 1);
    for (int i = 0; i < 7 && i < q1.size(); i++) check_val($sformatf("rr_ch1_%0d", i), q1[i], i + 10);
    ord_bits = '1;
    for (int i = 0; i < 14 && i < order.size(); i++) ord_bits[i] = order[i][0];
    check_val("rr_order", ord_bits, 14'h2AAA);
    check_val("rr_ovf", {ovf1, ovf0}, 2'b00);
    check_val("rr_hits", {hits0, hits1}, STATS ? {16'd7, 16'd7} : 32'd0);
    check_val("rr_drops", {drops0, drops1}, '0);

    // ch0 saturating, ch1 for 9 cycles: one drop each; clr_ovf with a drop keeps ovf1
    do_reset();
    for (int t = 0; t < 11; t++) begin
      ch0_valid = 1'b1; ch0_data = therm(3);
      ch1_valid = (t >= 2); ch1_data = therm(5);
      clr_ovf = (t == 10);
      tick();
      if (t == 9) check_val("drop_ovf_t9", {ovf1, ovf0}, 2'b01);
      if (t == 10) check_val("drop_ovf_t10", {ovf1, ovf0}, 2'b10);
    end
    idle_inputs();
    tick(40);
    check_val("drop_cnt0", q0.size(), 10);
    check_val("drop_cnt1", q1.size(), 8);
    check_val("drop_drops", {drops0, drops1}, STATS ? {16'd1, 16'd1} : 32'd0);
    check_val("drop_hits", {hits0, hits1}, STATS ? {16'd10, 16'd8} : 32'd0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_val("drop_clr", {ovf1, ovf0}, 2'b00);

    // Reset with words in flight
    do_reset();
    for (int t = 0; t < 5; t++) begin
      ch0_valid = 1'b1; ch0_data = therm(t + 1);
      tick();
    end
    idle_inputs();
    tick(3);
    clr_mon();
    rst_n = 1'b0;
    #1;
    check_val("flush_async_dec", dec_data, '0);
    tick(2);
    rst_n = 1'b1;
    tick(30);
    check_val("flush_no_res", q0.size() + q1.size(), 0);
    check_val("flush_outs", {dec_data, res0_pos, res1_pos, res0_valid, res1_valid, ovf0, ovf1}, '0);
    check_val("flush_stats", {hits0, hits1, drops0, drops1}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
